// File: rtl/seg_scan_decoder.sv
// Readback monitor for a multiplexed active-low 4-digit 7-segment bus.
// Samples each settled digit, decodes it to BCD and assembles MM:SS frames.
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned FRAME_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_i,
    input  logic [3:0] an_i,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       frame_valid,
    output logic       blank_o,
    output logic       err_o,
    output logic       stale_o
);

    localparam logic [1:0] StWait   = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StHold   = 2'd2;

    localparam logic [3:0] CodeBlank   = 4'hA;
    localparam logic [3:0] CodeInvalid = 4'hF;

    localparam logic [7:0]  SettleLast  = 8'(SETTLE_CYCLES - 1);
    localparam logic [19:0] TimeoutLast = 20'(FRAME_TIMEOUT - 1);

    logic [6:0] seg_m, seg_s, seg_p;
    logic [3:0] an_m, an_s, an_p;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [19:0] tcnt_q, tcnt_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0][3:0] slot_q;

    logic       an_valid;
    logic [1:0] an_pos;
    logic       changed;
    logic       fire;
    logic       timeout;
    logic       eval;
    logic       frame_good;
    logic       frame_blank;
    logic [3:0] seg_code;

    function automatic logic [3:0] seg_decode(input logic [6:0] s);
        logic [3:0] code;
        case (s)
            7'b1000000: code = 4'd0;
            7'b1111001: code = 4'd1;
            7'b0100100: code = 4'd2;
            7'b0110000: code = 4'd3;
            7'b0011001: code = 4'd4;
            7'b0010010: code = 4'd5;
            7'b0000010: code = 4'd6;
            7'b1111000: code = 4'd7;
            7'b0000000: code = 4'd8;
            7'b0010000: code = 4'd9;
            7'b1111111: code = CodeBlank;
            default:    code = CodeInvalid;
        endcase
        return code;
    endfunction

    assign seg_code = seg_decode(seg_s);
    assign changed  = (seg_s != seg_p) || (an_s != an_p);

    // Exactly one low anode bit selects a position; anything else is no-select.
    always_comb begin
        an_valid = 1'b1;
        an_pos   = 2'd0;
        case (an_s)
            4'b1110: an_pos = 2'd0;
            4'b1101: an_pos = 2'd1;
            4'b1011: an_pos = 2'd2;
            4'b0111: an_pos = 2'd3;
            default: an_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        case (state_q)
            StWait: begin
                if (an_valid) begin
                    state_d = StSettle;
                    cnt_d   = 8'd0;
                end
            end
            StSettle: begin
                if (!an_valid) begin
                    state_d = StWait;
                    cnt_d   = 8'd0;
                end else if (changed) begin
                    cnt_d = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHold: begin
                if (changed) begin
                    state_d = an_valid ? StSettle : StWait;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = StWait;
                cnt_d   = 8'd0;
            end
        endcase
        // The strobe fires on the edge where the counter lands on its last value.
        if (state_d == StSettle && cnt_d == SettleLast) begin
            fire    = 1'b1;
            state_d = StHold;
            cnt_d   = 8'd0;
        end
    end

    assign timeout = !fire && (tcnt_q == TimeoutLast);
    assign eval    = (mask_q == 4'hF);

    always_comb begin
        tcnt_d = tcnt_q + 20'd1;
        if (fire || timeout) begin
            tcnt_d = 20'd0;
        end
        mask_d = mask_q;
        if (eval || timeout) begin
            mask_d = 4'h0;
        end
        if (fire) begin
            mask_d[an_pos] = 1'b1;
        end
    end

    always_comb begin
        frame_good  = (slot_q[0] <= 4'd5) && (slot_q[1] <= 4'd9) &&
                      (slot_q[2] <= 4'd5) && (slot_q[3] <= 4'd9);
        frame_blank = (slot_q[0] == CodeBlank) && (slot_q[1] == CodeBlank) &&
                      (slot_q[2] == CodeBlank) && (slot_q[3] == CodeBlank);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_m       <= 7'h7F;
            seg_s       <= 7'h7F;
            seg_p       <= 7'h7F;
            an_m        <= 4'hF;
            an_s        <= 4'hF;
            an_p        <= 4'hF;
            state_q     <= StWait;
            cnt_q       <= 8'd0;
            tcnt_q      <= 20'd0;
            mask_q      <= 4'h0;
            slot_q      <= '0;
            min_tens    <= 4'd0;
            min_ones    <= 4'd0;
            sec_tens    <= 4'd0;
            sec_ones    <= 4'd0;
            minutes     <= 6'd0;
            seconds     <= 6'd0;
            frame_valid <= 1'b0;
            blank_o     <= 1'b0;
            err_o       <= 1'b0;
            stale_o     <= 1'b1;
        end else begin
            seg_m   <= seg_i;
            seg_s   <= seg_m;
            seg_p   <= seg_s;
            an_m    <= an_i;
            an_s    <= an_m;
            an_p    <= an_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            mask_q  <= mask_d;
            if (fire) begin
                slot_q[an_pos] <= seg_code;
            end

            frame_valid <= 1'b0;
            err_o       <= 1'b0;
            if (timeout) begin
                stale_o <= 1'b1;
            end
            if (eval) begin
                if (frame_good) begin
                    min_tens    <= slot_q[0];
                    min_ones    <= slot_q[1];
                    sec_tens    <= slot_q[2];
                    sec_ones    <= slot_q[3];
                    minutes     <= 6'(slot_q[0]) * 6'd10 + 6'(slot_q[1]);
                    seconds     <= 6'(slot_q[2]) * 6'd10 + 6'(slot_q[3]);
                    frame_valid <= 1'b1;
                    blank_o     <= 1'b0;
                    stale_o     <= 1'b0;
                end else if (frame_blank) begin
                    blank_o <= 1'b1;
                end else begin
                    err_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized self-checking bench for seg_scan_decoder against a frame-level
// model of what the scanned display is showing.
module tb_seg_scan_decoder;

    localparam int S = 8;
    localparam int T = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] seg = 7'h7F;
    logic [3:0] an = 4'hF;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [5:0] minutes, seconds;
    logic       frame_valid, blank_o, err_o, stale_o;

    seg_scan_decoder #(
        .SETTLE_CYCLES(S),
        .FRAME_TIMEOUT(T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_i      (seg),
        .an_i       (an),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .minutes    (minutes),
        .seconds    (seconds),
        .frame_valid(frame_valid),
        .blank_o    (blank_o),
        .err_o      (err_o),
        .stale_o    (stale_o)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    int fv_cnt = 0;
    int err_cnt = 0;
    int fv_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt <= fv_cnt + 1;
            fv_cyc <= cyc;
        end
        if (err_o) err_cnt <= err_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Glyph table, index = digit value
    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Model: 0..9 digit, 10 blank, -1 invalid
    int m_slot [4];
    bit m_mask [4];
    int e_fv = 0, e_err = 0, e_min = 0, e_sec = 0;
    int e_d [4] = '{0, 0, 0, 0};
    bit e_blank = 1'b0, e_stale = 1'b1;

    function automatic int decode(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (s == pat[i]) return i;
        if (s == 7'h7F) return 10;
        return -1;
    endfunction

    function automatic logic [6:0] rand_invalid();
        logic [6:0] p;
        do p = 7'($urandom); while (decode(p) != -1);
        return p;
    endfunction

    task automatic model_sample(input int pos, input int code);
        bit all_dec, all_blank;
        m_slot[pos] = code;
        m_mask[pos] = 1'b1;
        if (m_mask[0] && m_mask[1] && m_mask[2] && m_mask[3]) begin
            for (int i = 0; i < 4; i++) m_mask[i] = 1'b0;
            all_dec = 1'b1;
            all_blank = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (m_slot[i] < 0 || m_slot[i] > 9) all_dec = 1'b0;
                if (m_slot[i] != 10) all_blank = 1'b0;
            end
            if (all_dec && m_slot[0] <= 5 && m_slot[2] <= 5) begin
                e_fv++;
                for (int i = 0; i < 4; i++) e_d[i] = m_slot[i];
                e_min = m_slot[0] * 10 + m_slot[1];
                e_sec = m_slot[2] * 10 + m_slot[3];
                e_blank = 1'b0;
                e_stale = 1'b0;
            end else if (all_blank) begin
                e_blank = 1'b1;
            end else begin
                e_err++;
            end
        end
    endtask

    task automatic dwell(input int pos, input logic [6:0] s, input int len);
        seg = s;
        an = ~(4'b0001 << pos);
        repeat (len) @(posedge clk);
        #1;
        if (len >= S + 3) model_sample(pos, decode(s));
    endtask

    task automatic idle(input int len);
        an = 4'hF;
        seg = 7'h7F;
        repeat (len) @(posedge clk);
        #1;
        if (len > T) begin
            for (int i = 0; i < 4; i++) m_mask[i] = 1'b0;
            e_stale = 1'b1;
        end
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                        input logic [6:0] p3, input int len);
        dwell(0, p0, len);
        dwell(1, p1, len);
        dwell(2, p2, len);
        dwell(3, p3, len);
        idle(12);
    endtask

    task automatic check_all(input string tag);
        check({tag, "/fv_count"}, fv_cnt, e_fv);
        check({tag, "/err_count"}, err_cnt, e_err);
        check({tag, "/min_tens"}, int'(min_tens), e_d[0]);
        check({tag, "/min_ones"}, int'(min_ones), e_d[1]);
        check({tag, "/sec_tens"}, int'(sec_tens), e_d[2]);
        check({tag, "/sec_ones"}, int'(sec_ones), e_d[3]);
        check({tag, "/minutes"}, int'(minutes), e_min);
        check({tag, "/seconds"}, int'(seconds), e_sec);
        check({tag, "/blank"}, int'(blank_o), int'(e_blank));
        check({tag, "/stale"}, int'(stale_o), int'(e_stale));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/digits"}, int'({min_tens, min_ones, sec_tens, sec_ones}), 0);
        check({tag, "/minsec"}, int'({minutes, seconds}), 0);
        check({tag, "/fv"}, int'(frame_valid), 0);
        check({tag, "/err"}, int'(err_o), 0);
        check({tag, "/blank"}, int'(blank_o), 0);
        check({tag, "/stale"}, int'(stale_o), 1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_mask[i] = 1'b0;
            e_d[i] = 0;
        end
        e_min = 0;
        e_sec = 0;
        e_blank = 1'b0;
        e_stale = 1'b1;
    endtask

    initial begin
        int t0;
        logic [6:0] f [4];
        int kind, len;

        for (int i = 0; i < 4; i++) m_mask[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        idle(4);
        check_all("post_reset");

        // 12:34 with a latency check on the last position
        dwell(0, pat[1], 30);
        dwell(1, pat[2], 30);
        dwell(2, pat[3], 30);
        t0 = cyc;
        dwell(3, pat[4], 30);
        idle(12);
        check("latency_12_34", fv_cyc - t0, S + 3);
        check_all("frame_12_34");

        scan(7'h7F, 7'h7F, 7'h7F, 7'h7F, 20);
        check_all("all_blank");
        scan(pat[0], pat[0], pat[0], pat[5], 20);
        check_all("frame_00_05");

        scan(pat[2], pat[1], 7'b0001000, pat[7], 20);
        check_all("bad_glyph");
        scan(pat[6], pat[1], pat[2], pat[3], 20);
        check_all("min_tens_6");

        // Digit changes early in the dwell: only the settled glyph is sampled
        dwell(0, pat[2], 20);
        dwell(1, pat[3], 4);
        dwell(1, pat[7], 30);
        dwell(2, pat[4], 20);
        dwell(3, pat[5], 20);
        idle(12);
        check_all("resettle");

        // Partial frame then timeout; leftovers must not combine with a later half-frame
        dwell(0, pat[1], 20);
        dwell(1, pat[1], 20);
        idle(T + 10);
        check_all("timeout1");
        dwell(2, pat[2], 20);
        dwell(3, pat[2], 20);
        idle(12);
        check_all("half_after_timeout");
        idle(T + 10);
        check_all("timeout2");
        scan(pat[4], pat[5], pat[5], pat[9], 20);
        check_all("frame_45_59");

        for (int n = 0; n < 25; n++) begin
            kind = $urandom_range(0, 9);
            for (int i = 0; i < 4; i++) f[i] = pat[$urandom_range(0, 9)];
            f[0] = pat[$urandom_range(0, (kind == 9) ? 9 : 5)];
            f[2] = pat[$urandom_range(0, (kind == 8) ? 9 : 5)];
            if (kind == 0) for (int i = 0; i < 4; i++) f[i] = 7'h7F;
            if (kind == 1) f[$urandom_range(0, 3)] = rand_invalid();
            if (kind == 2) f[$urandom_range(0, 3)] = 7'h7F;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) dwell(i, rand_invalid(), $urandom_range(1, S - 2));
                len = $urandom_range(S + 3, S + 25);
                dwell(i, f[i], len);
            end
            idle(12);
            check_all($sformatf("rand%0d", n));
        end

        // Reset in the middle of a dwell discards the partial frame
        dwell(0, pat[3], 20);
        dwell(1, pat[3], 20);
        seg = pat[4];
        an = 4'b1011;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        model_reset();
        an = 4'hF;
        seg = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(4);
        check_all("after_reset");
        scan(pat[0], pat[8], pat[1], pat[7], 20);
        check_all("frame_08_17");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
